aes2x_round_engine: RTL
=======================

Name: aes2x_round_engine

Overview:
- Iterative AES-round sequencer that sits directly downstream of the 256-bit combinational sub_bytes stage in the SPHINCS+/Haraka datapath.
- Drives sub_bytes with its state register, consumes the substituted bytes, and completes each round by applying ShiftRows, MixColumns and AddRoundKey to two independent 128-bit AES blocks in parallel.
- Runs NUM_ROUNDS rounds per accepted input, at one round per cycle.
- Uses valid/ready handshakes on both input and output so Haraka permutation control can stall it.

Parameters:
- NUM_ROUNDS, 2, AES rounds per transaction (legal range 1..15).
- LAST_MIX, 1, 1 = apply MixColumns in the final round (aesenc); 0 = skip it in the final round (aesenclast).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state carries a valid block pair.
- in_ready  out  1  engine can accept an input.
- in_state  in  256  block A in [255:128], block B in [127:0].
- sbox_out  out  256  connected to sub_bytes sboxw.
- sbox_in  in  256  connected to sub_bytes new_sboxw; combinational result of sbox_out in the same cycle.
- rk_idx  out  4  index of the round key required in the current cycle.
- rk_in  in  256  round-key pair for rk_idx, presented combinationally in the same cycle.
- out_valid  out  1  out_state is valid.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  256  result block pair.

Behaviour:
- Byte order:
  - Each 128-bit block is column-major, FIPS-197 layout: byte 0 at [127:120] of the block, byte index = row + 4*col.
  - ShiftRows: out byte (r,c) = in byte (r, (c+r) mod 4).
  - MixColumns: standard GF(2^8) matrix [2 3 1 1] rotated, reduction polynomial 0x11B.
- Round datapath:
  - sbox_out = state_q at all times.
  - next = MC(SR(sbox_in)) XOR rk_in, applied per 128-bit half.
  - In the final round with LAST_MIX=0, the MC step is omitted.
- FSM states:
  - IDLE:
    - in_ready=1.
    - When in_valid=1: state_q<=in_state, rnd_q<=0, go to RUN.
  - RUN:
    - in_ready=0; rk_idx=rnd_q.
    - Each cycle: state_q<=next, rnd_q<=rnd_q+1.
    - When rnd_q==NUM_ROUNDS-1: go to DONE after this update.
  - DONE:
    - out_valid=1; out_state=state_q, held stable.
    - When out_ready=1: go to IDLE.
- Timing:
  - Latency from the input handshake cycle to out_valid=1 is NUM_ROUNDS+1 edges, so NUM_ROUNDS cycles spent in RUN.
  - Throughput is one transaction per NUM_ROUNDS+2 cycles when out_ready is held at 1.
- rk_idx is 0 outside RUN. rk_in is ignored outside RUN.
- The engine does not accept a new input in the same cycle out_valid is consumed; in_ready rises on the following cycle. No overlap is allowed.
- out_state while out_valid=0 equals state_q; it is don't-care to consumers and must not be checked.
- rnd_q is a 4-bit counter. It never wraps because NUM_ROUNDS<=15.
- RESET (takes priority over every other event, including RESET asserted mid-RUN or in DONE):
  - FSM<=IDLE, state_q<=0, rnd_q<=0.
  - Outputs during/after reset: in_ready=1, out_valid=0, rk_idx=0, out_state=0, sbox_out=0.
  - Any in-flight transaction is discarded without output.
- in_valid asserted while busy: no effect, and the input is not captured. The producer must hold it until in_ready=1.
- out_ready asserted while not in DONE: ignored.

Test Plan:
- FIPS-197 App.B round 1, NUM_ROUNDS=1, LAST_MIX=1:
  - Stimulus: both halves = 193de3bea0f4e22b9ac68d2ae9f84808; rk_in both halves = a0fafe1788542cb123a339392a6c7605.
  - Required: out_state halves = a49c7ff2689f352b6b5bea43026a5049; out_valid rises 2 edges after the handshake.
- NUM_ROUNDS=2, different halves (A = App.B vector, B = 0):
  - Stimulus: rk_idx 0/1 return App.B keys 1/2 (upper half) and 0 (lower half).
  - Required: upper half = App.B round-3 start state; lower half = reference-model value; rk_idx sequence observed as 0,1.
- LAST_MIX=0, NUM_ROUNDS=1, input 0, key 0 -> out_state = 6363...63 (all bytes 0x63).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_state stable, in_ready=0, new in_valid pulses ignored; after out_ready=1, IDLE the next cycle and in_ready=1.
- Reset mid-RUN:
  - Stimulus: assert RESET on the first RUN cycle with NUM_ROUNDS=2.
  - Required: next cycle IDLE, out_valid=0, out_state=0, no output ever produced; a following transaction gives correct results.
- Back-to-back transactions with out_ready tied 1 and in_valid tied 1 -> one result every NUM_ROUNDS+2 cycles, each matching the reference model.

Source files
------------

// File: rtl/aes2x_round_engine_if.sv
// Handshake, sub_bytes and round-key bundle for aes2x_round_engine.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface aes2x_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_state;
    logic [255:0] sbox_out;
    logic [255:0] sbox_in;
    logic [3:0]   rk_idx;
    logic [255:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_state;

    // Environment side: producer, sub_bytes stage, key store and consumer.
    modport master (
        output in_valid,
        output in_state,
        output sbox_in,
        output rk_in,
        output out_ready,
        input  in_ready,
        input  sbox_out,
        input  rk_idx,
        input  out_valid,
        input  out_state
    );

    // Engine side.
    modport slave (
        input  in_valid,
        input  in_state,
        input  sbox_in,
        input  rk_in,
        input  out_ready,
        output in_ready,
        output sbox_out,
        output rk_idx,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/aes2x_round_engine.sv
// Iterative dual-block AES round engine: ShiftRows/MixColumns/AddRoundKey after external sub_bytes.
// Latency: NUM_ROUNDS+1 edges from input handshake to out_valid; one transaction in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no overlap.
module aes2x_round_engine #(
    parameter int NUM_ROUNDS = 2,
    parameter bit LAST_MIX   = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    aes2x_round_engine_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [255:0] state_q;
    logic [255:0] state_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic         mix_en;
    logic [255:0] round_next;

    // GF(2^8) multiply-by-two with the AES reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of a column-major block sits at [127-8*i -: 8], i = row + 4*col.
    function automatic logic [127:0] shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(r + 4*c) -: 8] = blk[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return res;
    endfunction

    // One column through the circulant [2 3 1 1] matrix.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[127 - 32*c -: 32] = mix_col(blk[127 - 32*c -: 32]);
        end
        return res;
    endfunction

    // Completes a round on one 128-bit half whose bytes are already substituted.
    function automatic logic [127:0] finish_round(input logic [127:0] sb,
                                                  input logic [127:0] key,
                                                  input logic         mix);
        logic [127:0] sr;
        sr = shift_rows(sb);
        return (mix ? mix_columns(sr) : sr) ^ key;
    endfunction

    // sub_bytes sees the state register directly; out_state is the same register.
    assign bus.sbox_out  = state_q;
    assign bus.out_state = state_q;

    // Handshake and key-index outputs decoded from the current state only, so the
    // combinational key lookup and sbox paths never loop back into them.
    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.rk_idx    = (fsm_q == RUN) ? rnd_q : 4'd0;

    // MixColumns runs every round except a final aesenclast-style round.
    assign mix_en     = LAST_MIX || (rnd_q != LAST_RND);
    assign round_next = {finish_round(bus.sbox_in[255:128], bus.rk_in[255:128], mix_en),
                         finish_round(bus.sbox_in[127:0],   bus.rk_in[127:0],   mix_en)};

    // Next-state logic: capture in IDLE, iterate rounds in RUN, hold result in DONE.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.in_state;
                    rnd_d   = 4'd0;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_next;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that overrides any in-flight work.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule
